// File: rtl/symbol_write_control_pkg.sv
// Shared definitions for the symbol FIFO write side and its read-side counterparts:
// controller state encoding and symbols-per-byte derivation.
package symbol_write_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } fifo_state_e;

  function automatic int calc_nsym(input int in_w, input int sym_w);
    return in_w / sym_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/symbol_write_control_edge_strobe.sv
// Samples a slow clock-like input once in the fast domain and emits a
// one-cycle pulse for every 0->1 transition seen.
module edge_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_pulse
);

  logic level_q, level_d;
  logic pulse_q, pulse_d;

  always_comb begin
    level_d = i_sig;
    pulse_d = i_sig & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/symbol_write_control.sv
// Splits slow-clocked input bytes into SYM_W-bit symbols and writes them to a
// symbol RAM, MSB symbol first, with stop-at-full or circular addressing.
module symbol_write_control
  import symbol_write_control_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int SYM_W     = 2,
  parameter int DEPTH     = 288,
  parameter int ADDR_W    = 9,
  parameter int WRAP_MODE = 0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_clock_data,
  input  logic [IN_W-1:0]   i_data_in,
  input  logic              i_restart,
  output logic [SYM_W-1:0]  o_data_write,
  output logic [ADDR_W-1:0] o_addr_write,
  output logic              o_enab_write,
  output logic              o_data_empt,
  output logic              o_data_full,
  output logic              o_overrun,
  output logic [1:0]        o_dbg_state
);

  localparam int NSYM  = calc_nsym(IN_W, SYM_W);
  localparam int CNT_W = cnt_width(NSYM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_SYM  = CNT_W'(NSYM - 1);

  logic dv;

  edge_strobe u_edge (
    .clk    (i_clock),
    .rst_n  (i_reset_n),
    .i_sig  (i_clock_data),
    .o_pulse(dv)
  );

  fifo_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [SYM_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              enab_q, enab_d;
  logic              empt_q, empt_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;

  logic [IN_W-1:0]   shifted;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_sym;
  logic              at_last;
  logic              accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    addr_d   = addr_q;
    enab_d   = 1'b0;
    empt_d   = empt_q;
    ovr_d    = 1'b0;
    accept   = 1'b0;
    shifted  = shift_q << SYM_W;
    last_sym = (cnt_q == LAST_SYM);
    at_last  = (addr_q == LAST_ADDR);
    addr_inc = at_last ? '0 : addr_q + 1'b1;

    if (i_restart) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      empt_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: accept = dv;
        ST_SHIFT: begin
          // A write is in flight this cycle; advance past it.
          addr_d = addr_inc;
          if (at_last && (WRAP_MODE == 0)) begin
            state_d = ST_STOP;
          end else if (last_sym) begin
            if (dv) accept = 1'b1;
            else    state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shifted;
            data_d  = shifted[IN_W-1 -: SYM_W];
            enab_d  = 1'b1;
            ovr_d   = dv;
          end
        end
        ST_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shift_d = i_data_in;
      data_d  = i_data_in[IN_W-1 -: SYM_W];
      enab_d  = 1'b1;
      empt_d  = 1'b0;
    end

    // Stop mode holds full as a level; wrap mode flags the last-address write.
    full_d = (WRAP_MODE != 0) ? (enab_d && (addr_d == LAST_ADDR)) : (state_d == ST_STOP);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      enab_q  <= 1'b0;
      empt_q  <= 1'b1;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      enab_q  <= enab_d;
      empt_q  <= empt_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data_write = data_q;
  assign o_addr_write = addr_q;
  assign o_enab_write = enab_q;
  assign o_data_empt  = empt_q;
  assign o_data_full  = full_q;
  assign o_overrun    = ovr_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/symbol_write_control.md
SYMBOL_WRITE_CONTROL -- requirements
Module: symbol_write_control

Interface
REQ-001 Parameter IN_W, default 8, meaning: input byte width in bits.
REQ-002 Parameter SYM_W, default 2, meaning: symbol width written per RAM access; IN_W shall be an integer multiple of SYM_W.
REQ-003 Parameter DEPTH, default 288, meaning: RAM depth in symbols.
REQ-004 Parameter ADDR_W, default 9, meaning: address width; 2**ADDR_W >= DEPTH.
REQ-005 Parameter WRAP_MODE, default 0, meaning: 0 = stop at full, 1 = circular overwrite.
REQ-006 i_clock  in  1  system clock; all logic on its rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_clock_data  in  1  slow data clock; sampled in the i_clock domain.
REQ-009 i_data_in  in  IN_W  input byte; valid at the rising edge of i_clock_data.
REQ-010 i_restart  in  1  single-cycle pulse; leaves STOP and rearms the block.
REQ-011 o_data_write  out  SYM_W  symbol to RAM.
REQ-012 o_addr_write  out  ADDR_W  RAM write address.
REQ-013 o_enab_write  out  1  RAM write enable.
REQ-014 o_data_empt  out  1  high while no symbol has been written since reset or restart.
REQ-015 o_data_full  out  1  STOP mode: level, held in STOP; WRAP mode: one-cycle pulse.
REQ-016 o_overrun  out  1  one-cycle pulse when a byte is dropped.

Function
REQ-017 The block shall register i_clock_data once and raise internal strobe DV for exactly one cycle, one cycle after a 0->1 transition is sampled.
REQ-018 The block shall capture i_data_in into a shift register in the DV cycle when the byte is accepted.
REQ-019 Let NSYM = IN_W/SYM_W; an accepted byte shall produce NSYM write cycles on consecutive clocks starting the cycle after DV, MSB symbol first, o_enab_write high in each.
REQ-020 The FSM shall have the states IDLE, SHIFT and STOP; IDLE->SHIFT on accepted DV; SHIFT->IDLE after symbol NSYM unless a new byte is accepted; any state->STOP on full in WRAP_MODE=0; STOP->IDLE on i_restart.
REQ-021 A DV shall be accepted in IDLE, or in the final SHIFT cycle (back-to-back bytes, no gap); a DV in any other SHIFT cycle shall drop the byte and pulse o_overrun.
REQ-022 The first write after reset or restart shall use address 0; the address shall increment by 1 after every write.
REQ-023 The write to address DEPTH-1 shall be the full event.
REQ-024 For a full event with WRAP_MODE=0, that write shall complete; the remaining symbols of the byte shall be discarded; the next cycle shall be STOP with o_data_full=1, o_enab_write=0 and address 0; DV in STOP shall be ignored with no o_overrun.
REQ-025 For a full event with WRAP_MODE=1, o_data_full shall pulse in the cycle of the DEPTH-1 write, the next address shall be 0, and writing shall continue.
REQ-026 i_restart in any state shall clear o_data_full, set o_data_empt and set the address to 0 with o_enab_write=0; i_restart wins over a simultaneous DV.
REQ-027 o_data_empt shall fall in the cycle of the first write.
REQ-028 The address shall never exceed DEPTH-1.

Reset
REQ-029 While i_reset_n=0, the state shall be IDLE and the outputs shall be o_data_write=0, o_addr_write=0, o_enab_write=0, o_data_full=0, o_overrun=0, o_data_empt=1; the edge register, DV and the shift register shall be 0.
REQ-030 Reset asserted mid-byte shall abort the byte immediately with no further writes.

Structure
REQ-031 The FSM state encodings and the NSYM derivation shall reside in a shared package with the FIFO read-side blocks.
REQ-032 The edge detector shall be one sub-module, edge_strobe (register plus rising-edge pulse), reusable by the read side.

Verification
REQ-033 The bench shall check: reset, then one byte 0xB4 with defaults -> writes at addresses 0,1,2,3 with data 2,3,1,0; o_data_empt falls at the first write.
REQ-034 The bench shall check: 72 bytes with WRAP_MODE=0 -> 288 writes; o_data_full rises after address 287; a 73rd byte produces no write.
REQ-035 The bench shall check: WRAP_MODE=1, 73 bytes -> o_data_full pulses at address 287; byte 73 writes at addresses 0..3.
REQ-036 The bench shall check: a second data-clock edge two cycles after the first -> o_overrun pulses once; the second byte produces no write.
REQ-037 The bench shall check: i_restart and DV in the same cycle while in STOP -> IDLE, address 0, no write; the next byte writes at address 0.
REQ-038 The bench shall check: i_reset_n low during the write of symbol 2 -> o_enab_write=0 at once; after release, the next byte writes at address 0.
